tx_pkt_padder: RTL and testbench

Stage directly upstream of the MAC transmit queue, in the core clock domain. It takes packets from the output-queue read path and passes module-header words through untouched. Frames shorter than the Ethernet minimum are zero-padded, bytes beyond the last valid byte are zeroed, and the end-of-packet control is regenerated so the transmit queue's byte-granular EOP logic sees a legal frame. Per-packet byte length and done/padded pulses go to the register block.

---
 rtl/tx_pkt_padder.sv | 126 ++++++++++++
 tb/tb_tx_pkt_padder.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pkt_padder.sv
// tx_pkt_padder: pads short frames, zeroes trailing bytes and regenerates EOP ctrl ahead of the MAC transmit queue
module tx_pkt_padder #(
  parameter int DATA_WIDTH    = 64,
  parameter int CTRL_WIDTH    = DATA_WIDTH/8,
  parameter bit ENABLE_HEADER = 1'b0,
  parameter int MIN_PKT_BYTES = 60
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic                  pad_en,
  output logic                  pkt_done,
  output logic                  pkt_padded,
  output logic [11:0]           pkt_byte_len
);
  localparam int KW = $clog2(CTRL_WIDTH);
  localparam int LAST_W = (MIN_PKT_BYTES-1)/CTRL_WIDTH;
  localparam int LAST_K = (MIN_PKT_BYTES-1)%CTRL_WIDTH;
  localparam logic [CTRL_WIDTH-1:0] LAST_CTRL = CTRL_WIDTH'(1) << (CTRL_WIDTH-1-LAST_K);
  typedef enum logic [1:0] {IDLE, IN_PKT, PAD} state_t;
  state_t state_q, state_d;
  logic [8:0] word_idx_q, word_idx_d, idx;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, mask;
  logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
  logic out_wr_q, out_wr_d, pkt_done_q, pkt_done_d, pkt_padded_q, pkt_padded_d;
  logic [11:0] pkt_byte_len_q, pkt_byte_len_d;
  logic [KW-1:0] k;
  logic [12:0] len_full;
  logic [11:0] len;
  logic short_pkt, hdr;
  assign in_rdy = out_rdy && state_q != PAD && !reset;
  assign out_data = out_data_q;
  assign out_ctrl = out_ctrl_q;
  assign out_wr = out_wr_q;
  assign pkt_done = pkt_done_q;
  assign pkt_padded = pkt_padded_q;
  assign pkt_byte_len = pkt_byte_len_q;
  // EOP byte resolution, length arithmetic and next-state/output selection
  always_comb begin
    k = '0;
    for (int i = 0; i < CTRL_WIDTH; i++) if (in_ctrl[i]) k = KW'(CTRL_WIDTH-1-i);
    mask = '0;
    for (int j = 0; j < CTRL_WIDTH; j++) mask[DATA_WIDTH-1-8*j -: 8] = (j <= int'(k)) ? 8'hFF : 8'h00;
    idx = (state_q == IDLE) ? 9'd0 : word_idx_q;
    len_full = 13'(idx) * 13'(CTRL_WIDTH) + 13'(k) + 13'd1;
    len = (len_full > 13'd4095) ? 12'hFFF : len_full[11:0];
    short_pkt = pad_en && (len_full < 13'(MIN_PKT_BYTES));
    hdr = ENABLE_HEADER && state_q == IDLE && in_ctrl != '0;
    state_d = state_q;
    word_idx_d = word_idx_q;
    out_wr_d = 1'b0;
    out_data_d = '0;
    out_ctrl_d = '0;
    pkt_done_d = 1'b0;
    pkt_padded_d = 1'b0;
    pkt_byte_len_d = pkt_byte_len_q;
    if (state_q == PAD) begin
      if (out_rdy) begin
        out_wr_d = 1'b1;
        if (word_idx_q == 9'(LAST_W)) begin
          out_ctrl_d = LAST_CTRL;
          pkt_done_d = 1'b1;
          pkt_padded_d = 1'b1;
          pkt_byte_len_d = 12'(MIN_PKT_BYTES);
          state_d = IDLE;
        end else word_idx_d = word_idx_q + 9'd1;
      end
    end else if (in_wr && in_rdy) begin
      out_wr_d = 1'b1;
      if (hdr) begin
        out_data_d = in_data;
        out_ctrl_d = in_ctrl;
      end else if (in_ctrl == '0) begin
        out_data_d = in_data;
        state_d = IN_PKT;
        word_idx_d = (idx == 9'd511) ? idx : idx + 9'd1;
      end else begin
        out_data_d = in_data & mask;
        if (!short_pkt) begin
          out_ctrl_d = CTRL_WIDTH'(1) << (CTRL_WIDTH-1-int'(k));
          pkt_done_d = 1'b1;
          pkt_byte_len_d = len;
          state_d = IDLE;
        end else if (idx == 9'(LAST_W)) begin
          out_ctrl_d = LAST_CTRL;
          pkt_done_d = 1'b1;
          pkt_padded_d = 1'b1;
          pkt_byte_len_d = 12'(MIN_PKT_BYTES);
          state_d = IDLE;
        end else begin
          state_d = PAD;
          word_idx_d = idx + 9'd1;
        end
      end
    end
  end
  // register state and all outputs; reset abandons any partial packet
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_idx_q <= '0;
      out_wr_q <= 1'b0;
      out_data_q <= '0;
      out_ctrl_q <= '0;
      pkt_done_q <= 1'b0;
      pkt_padded_q <= 1'b0;
      pkt_byte_len_q <= '0;
    end else begin
      state_q <= state_d;
      word_idx_q <= word_idx_d;
      out_wr_q <= out_wr_d;
      out_data_q <= out_data_d;
      out_ctrl_q <= out_ctrl_d;
      pkt_done_q <= pkt_done_d;
      pkt_padded_q <= pkt_padded_d;
      pkt_byte_len_q <= pkt_byte_len_d;
    end
  end
endmodule

// File: tb/tb_tx_pkt_padder.sv
// tb_tx_pkt_padder: randomized bench against a byte-level frame model
module tb_tx_pkt_padder;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int MIN = 60;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic [CW-1:0] in_ctrl = '0;
  logic in_wr = 1'b0, out_rdy = 1'b1, pad_en = 1'b1;
  logic in_rdy, out_wr, pkt_done, pkt_padded;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [11:0] pkt_byte_len;
  always #5 clk = ~clk;
  tx_pkt_padder #(.DATA_WIDTH(DW), .ENABLE_HEADER(1'b1), .MIN_PKT_BYTES(MIN)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy), .pad_en(pad_en),
    .pkt_done(pkt_done), .pkt_padded(pkt_padded), .pkt_byte_len(pkt_byte_len)
  );
  int passed = 0, total = 0, cyc = 0, dones = 0, stall_wr = 0;
  logic rdy_e = 1'b1;
  logic [DW-1:0] obs_d[$], exp_d[$], pw[$];
  logic [CW-1:0] obs_c[$], exp_c[$];
  logic [CW-1:0] lc;
  int obs_cyc[$], obs_len[$], exp_len[$], acc_cyc[$];
  bit obs_pad[$], exp_pad[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rdy_e <= out_rdy;
  end
  always @(negedge clk) begin
    if (out_wr) begin
      obs_d.push_back(out_data);
      obs_c.push_back(out_ctrl);
      obs_cyc.push_back(cyc);
      if (!rdy_e) stall_wr++;
    end
    if (pkt_done) begin
      obs_len.push_back(int'(pkt_byte_len));
      obs_pad.push_back(pkt_padded);
      dones++;
    end
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic clr_exp();
    exp_d.delete();
    exp_c.delete();
    exp_len.delete();
    exp_pad.delete();
  endtask
  task automatic send_word(input logic [DW-1:0] d, input logic [CW-1:0] c, input bit rnd);
    int g = 0;
    if (rnd) begin out_rdy = ($urandom_range(0, 3) != 0); #1; end
    while (!in_rdy && g < 200) begin
      step();
      if (rnd) begin out_rdy = ($urandom_range(0, 3) != 0); #1; end
      g++;
    end
    if (!in_rdy) begin total++; $display("FAIL send_timeout: in_rdy=%0b want 1", in_rdy); end
    in_data = d;
    in_ctrl = c;
    in_wr = 1'b1;
    acc_cyc.push_back(cyc);
    step();
    in_wr = 1'b0;
  endtask
  task automatic gen_pkt(input int nw, input int k, input bit junk);
    pw.delete();
    for (int i = 0; i < nw; i++) pw.push_back({$urandom(), $urandom()});
    lc = CW'(1) << (CW-1-k);
    if (junk) lc = lc | (CW'($urandom()) & (lc - CW'(1)));
  endtask
  task automatic model(input bit pe);
    logic [7:0] b[$];
    logic [DW-1:0] wd;
    int kk = 0, len, nwo;
    bit pd;
    for (int j = CW-1; j >= 0; j--) if (lc[CW-1-j]) kk = j;
    for (int w = 0; w < pw.size(); w++) begin
      wd = pw[w];
      for (int j = 0; j < CW; j++) if (w < pw.size()-1 || j <= kk) b.push_back(wd[DW-1-8*j -: 8]);
    end
    pd = pe && b.size() < MIN;
    while (pd && b.size() < MIN) b.push_back(8'h00);
    len = b.size();
    while (b.size() % CW != 0) b.push_back(8'h00);
    nwo = b.size() / CW;
    for (int w = 0; w < nwo; w++) begin
      wd = '0;
      for (int j = 0; j < CW; j++) wd[DW-1-8*j -: 8] = b[w*CW+j];
      exp_d.push_back(wd);
      exp_c.push_back((w == nwo-1) ? (CW'(1) << (CW-1-(len-1)%CW)) : CW'(0));
    end
    exp_len.push_back(len);
    exp_pad.push_back(pd);
  endtask
  task automatic send_pkt(input bit pe, input bit rnd);
    pad_en = pe;
    for (int i = 0; i < pw.size(); i++) send_word(pw[i], (i == pw.size()-1) ? lc : CW'(0), rnd);
  endtask
  task automatic wait_done(input int target);
    int g = 0;
    out_rdy = 1'b1;
    while (dones < target && g < 500) begin step(); g++; end
    total++;
    if (dones < target) $display("FAIL done_timeout: dones=%0d want %0d", dones, target);
    else passed++;
  endtask
  function automatic int mismatch(input int bd);
    if (obs_d.size() - bd != exp_d.size()) return -2;
    for (int i = 0; i < exp_d.size(); i++)
      if (obs_d[bd+i] !== exp_d[i] || obs_c[bd+i] !== exp_c[i]) return i;
    return -1;
  endfunction
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    total++;
    if ({out_wr, pkt_done, pkt_padded} !== 3'b000) $display("FAIL reset_strobes: got %b want 000", {out_wr, pkt_done, pkt_padded});
    else passed++;
    total++;
    if (out_data !== '0 || out_ctrl !== '0) $display("FAIL reset_data: got %h/%h want 0/0", out_data, out_ctrl);
    else passed++;
    total++;
    if (pkt_byte_len !== 12'd0) $display("FAIL reset_len: got %0d want 0", pkt_byte_len);
    else passed++;
    total++;
    if (in_rdy !== 1'b0) $display("FAIL reset_rdy: got %b want 0", in_rdy);
    else passed++;
    reset = 1'b0;
    step();
  endtask
  task automatic test_long();
    int b = obs_d.size(), a = acc_cyc.size(), bl = obs_len.size(), d0 = dones, m;
    clr_exp();
    gen_pkt(9, 0, 1'b0);
    model(1'b1);
    send_pkt(1'b1, 1'b0);
    wait_done(d0 + 1);
    m = mismatch(b);
    total++;
    if (m != -1) $display("FAIL long_words: mismatch at %0d, got %0d words want %0d", m, obs_d.size()-b, exp_d.size());
    else passed++;
    total++;
    if (obs_len[bl] !== 65) $display("FAIL long_len: got %0d want 65", obs_len[bl]);
    else passed++;
    total++;
    if (obs_pad[bl] !== 1'b0) $display("FAIL long_padded: got %b want 0", obs_pad[bl]);
    else passed++;
    total++;
    if (obs_cyc[b] - acc_cyc[a] != 1) $display("FAIL long_lat_first: got %0d want 1", obs_cyc[b] - acc_cyc[a]);
    else passed++;
    total++;
    if (obs_cyc[b+8] - acc_cyc[a+8] != 1) $display("FAIL long_lat_last: got %0d want 1", obs_cyc[b+8] - acc_cyc[a+8]);
    else passed++;
  endtask
  task automatic test_pad();
    int b = obs_d.size(), bl = obs_len.size(), d0 = dones, m, zc = 0;
    clr_exp();
    gen_pkt(2, 2, 1'b0);
    model(1'b1);
    send_pkt(1'b1, 1'b0);
    while (!in_rdy && zc < 50) begin zc++; step(); end
    wait_done(d0 + 1);
    m = mismatch(b);
    total++;
    if (m != -1) $display("FAIL pad_words: mismatch at %0d", m);
    else passed++;
    total++;
    if (obs_d.size() - b != 8) $display("FAIL pad_count: got %0d want 8", obs_d.size() - b);
    else passed++;
    total++;
    if (obs_len[bl] !== 60 || obs_pad[bl] !== 1'b1) $display("FAIL pad_len: got %0d/%b want 60/1", obs_len[bl], obs_pad[bl]);
    else passed++;
    total++;
    if (zc != 6) $display("FAIL pad_rdy_low: got %0d cycles want 6", zc);
    else passed++;
  endtask
  task automatic test_nopad();
    int b = obs_d.size(), bl = obs_len.size(), d0 = dones, m;
    clr_exp();
    model(1'b0);
    send_pkt(1'b0, 1'b0);
    wait_done(d0 + 1);
    m = mismatch(b);
    total++;
    if (m != -1) $display("FAIL nopad_words: mismatch at %0d", m);
    else passed++;
    total++;
    if (obs_d.size() - b != 2 || obs_c[b+1] !== 8'h20) $display("FAIL nopad_eop: got %0d words ctrl %h want 2 words ctrl 20", obs_d.size() - b, obs_c[b+1]);
    else passed++;
    total++;
    if (obs_len[bl] !== 11 || obs_pad[bl] !== 1'b0) $display("FAIL nopad_len: got %0d/%b want 11/0", obs_len[bl], obs_pad[bl]);
    else passed++;
  endtask
  task automatic test_exact();
    int b = obs_d.size(), bl = obs_len.size(), d0 = dones, m;
    clr_exp();
    gen_pkt(8, 1, 1'b0);
    model(1'b1);
    send_pkt(1'b1, 1'b0);
    total++;
    if (in_rdy !== 1'b1) $display("FAIL exact_no_pad_state: in_rdy got %b want 1", in_rdy);
    else passed++;
    wait_done(d0 + 1);
    m = mismatch(b);
    total++;
    if (m != -1) $display("FAIL exact_words: mismatch at %0d", m);
    else passed++;
    total++;
    if (obs_c[b+7] !== 8'h10 || obs_d[b+7][47:0] !== 48'h0) $display("FAIL exact_last: ctrl %h data %h want ctrl 10 low bytes 0", obs_c[b+7], obs_d[b+7]);
    else passed++;
    total++;
    if (obs_len[bl] !== 60 || obs_pad[bl] !== 1'b1) $display("FAIL exact_len: got %0d/%b want 60/1", obs_len[bl], obs_pad[bl]);
    else passed++;
  endtask
  task automatic test_stall();
    int b = obs_d.size(), d0 = dones, s0 = stall_wr, m;
    clr_exp();
    gen_pkt(2, 2, 1'b0);
    model(1'b1);
    send_pkt(1'b1, 1'b0);
    step();
    out_rdy = 1'b0;
    repeat (3) step();
    out_rdy = 1'b1;
    wait_done(d0 + 1);
    m = mismatch(b);
    total++;
    if (m != -1) $display("FAIL stall_words: mismatch at %0d", m);
    else passed++;
    total++;
    if (stall_wr != s0) $display("FAIL stall_wr: got %0d writes while stalled want 0", stall_wr - s0);
    else passed++;
    total++;
    if (obs_cyc[b+7] - obs_cyc[b] != 10) $display("FAIL stall_span: got %0d cycles want 10", obs_cyc[b+7] - obs_cyc[b]);
    else passed++;
  endtask
  task automatic test_header_reset();
    int b = obs_d.size(), bl = obs_len.size(), d0 = dones, m;
    logic [DW-1:0] hdr = {$urandom(), $urandom()};
    clr_exp();
    exp_d.push_back(hdr);
    exp_c.push_back(8'hFF);
    send_word(hdr, 8'hFF, 1'b0);
    gen_pkt(8, 3, 1'b0);
    model(1'b1);
    send_pkt(1'b1, 1'b0);
    wait_done(d0 + 1);
    m = mismatch(b);
    total++;
    if (m != -1) $display("FAIL hdr_words: mismatch at %0d", m);
    else passed++;
    total++;
    if (obs_len[bl] !== 60 || obs_pad[bl] !== 1'b0) $display("FAIL hdr_len: got %0d/%b want 60/0", obs_len[bl], obs_pad[bl]);
    else passed++;
    gen_pkt(6, 0, 1'b0);
    for (int i = 0; i < 4; i++) send_word(pw[i], '0, 1'b0);
    in_data = pw[4];
    in_ctrl = '0;
    in_wr = 1'b1;
    reset = 1'b1;
    step();
    in_wr = 1'b0;
    total++;
    if (out_wr !== 1'b0 || pkt_done !== 1'b0) $display("FAIL rst_mid_wr: got %b/%b want 0/0", out_wr, pkt_done);
    else passed++;
    total++;
    if (pkt_byte_len !== 12'd0) $display("FAIL rst_mid_len: got %0d want 0", pkt_byte_len);
    else passed++;
    step();
    reset = 1'b0;
    step();
    d0 = dones;
    b = obs_d.size();
    bl = obs_len.size();
    clr_exp();
    gen_pkt(3, 5, 1'b0);
    model(1'b1);
    send_pkt(1'b1, 1'b0);
    wait_done(d0 + 1);
    repeat (3) step();
    m = mismatch(b);
    total++;
    if (m != -1) $display("FAIL rst_fresh_words: mismatch at %0d", m);
    else passed++;
    total++;
    if (dones != d0 + 1 || obs_len[bl] !== 60) $display("FAIL rst_fresh_done: got %0d pulses len %0d want 1 pulse len 60", dones - d0, obs_len[bl]);
    else passed++;
  endtask
  task automatic test_back_to_back();
    int b = obs_d.size(), d0 = dones, m;
    clr_exp();
    gen_pkt(8, 7, 1'b0);
    model(1'b1);
    send_pkt(1'b1, 1'b0);
    gen_pkt(8, 7, 1'b0);
    model(1'b1);
    send_pkt(1'b1, 1'b0);
    wait_done(d0 + 2);
    m = mismatch(b);
    total++;
    if (m != -1) $display("FAIL b2b_words: mismatch at %0d", m);
    else passed++;
    total++;
    if (obs_cyc[b+8] - obs_cyc[b+7] != 1) $display("FAIL b2b_gap: got %0d want 1", obs_cyc[b+8] - obs_cyc[b+7]);
    else passed++;
  endtask
  task automatic test_random();
    int b = obs_d.size(), bl = obs_len.size(), d0 = dones, s0 = stall_wr, m, bad = -1;
    bit pe;
    clr_exp();
    for (int p = 0; p < 25; p++) begin
      pe = 1'($urandom_range(0, 1));
      gen_pkt($urandom_range(2, 10), $urandom_range(0, CW-1), 1'b1);
      model(pe);
      send_pkt(pe, 1'b1);
    end
    wait_done(d0 + 25);
    m = mismatch(b);
    total++;
    if (m != -1) $display("FAIL rand_words: mismatch at %0d, got %0d words want %0d", m, obs_d.size()-b, exp_d.size());
    else passed++;
    for (int i = 24; i >= 0; i--) if (obs_len[bl+i] !== exp_len[i] || obs_pad[bl+i] !== exp_pad[i]) bad = i;
    total++;
    if (bad != -1) $display("FAIL rand_len: pkt %0d got %0d/%b want %0d/%b", bad, obs_len[bl+bad], obs_pad[bl+bad], exp_len[bad], exp_pad[bad]);
    else passed++;
    total++;
    if (stall_wr != s0) $display("FAIL rand_stall_wr: got %0d want 0", stall_wr - s0);
    else passed++;
  endtask
  initial begin
    test_reset();
    test_long();
    test_pad();
    test_nopad();
    test_exact();
    test_stall();
    test_header_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
